// File: rtl/dsp_sequencer.sv
// dsp_sequencer: frame-triggered program sequencer and program-RAM arbiter for the audio_engine MAC datapath.
// Optional macro DSP_SINGLE_STEP_EN adds step_mode/step ports for single-stepping the RUN state.
module dsp_sequencer #(
  parameter int CODE_W             = 8,
  parameter bit OVR_CLEAR_ON_START = 1'b0
) (
  input  logic              ck,
  input  logic              rst,
  input  logic              start,
  input  logic              cpu_req,
  output logic              cpu_gnt,
  input  logic              ovr_clr,
`ifdef DSP_SINGLE_STEP_EN
  input  logic              step_mode,
  input  logic              step,
`endif
  output logic [CODE_W-1:0] prog_addr,
  output logic              prog_re,
  input  logic [31:0]       prog_data,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic              mac_en,
  output logic              mac_zero,
  output logic              save_en,
  output logic              capture_en,
  output logic [2:0]        capture_code,
  output logic [4:0]        op_offset,
  output logic [3:0]        op_chan,
  output logic [15:0]       op_gain
);

  localparam logic [6:0] OP_MAC  = 7'b1000000;
  localparam logic [6:0] OP_MACZ = 7'b1000010;
  localparam logic [6:0] OP_SAVE = 7'b1010000;
  localparam logic [6:0] OP_HALT = 7'b1111111;

  typedef enum logic [1:0] {IDLE, FETCH, RUN, DONE} state_t;

  state_t            state, state_d;
  logic [CODE_W-1:0] pc, pc_d;
  logic              pending, last, last_d, issue, go, adv, is_cap;
  logic [6:0]        opc;

  assign opc    = prog_data[31:25];
  assign is_cap = (opc[6:3] == 4'b0010);
  assign go     = (start | pending) & ~cpu_req;
  assign busy   = (state == FETCH) | (state == RUN);
  assign done   = (state == DONE);

`ifdef DSP_SINGLE_STEP_EN
  assign adv = ~step_mode | step;
`else
  assign adv = 1'b1;
`endif

  always_comb begin
    state_d   = state;
    pc_d      = pc;
    last_d    = last;
    prog_re   = 1'b0;
    prog_addr = pc;
    issue     = 1'b0;
    case (state)
      IDLE: if (go) state_d = FETCH;
      FETCH: begin
        prog_re   = 1'b1;
        prog_addr = '0;
        pc_d      = '0;
        pc_d[0]   = 1'b1;
        state_d   = RUN;
      end
      RUN: begin
        // pc==0 here means the top word is in flight; show it rather than a wrapped 0
        if (pc == '0) prog_addr = pc - 1'b1;
        if (last || opc == OP_HALT) begin
          state_d = DONE;
        end else if (!adv) begin
          prog_re   = 1'b1;
          prog_addr = pc - 1'b1;
        end else begin
          issue = 1'b1;
          if (pc == '0) begin
            last_d = 1'b1;
          end else begin
            prog_re = 1'b1;
            pc_d    = pc + 1'b1;
          end
        end
      end
      DONE: begin
        pc_d    = '0;
        last_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ck) begin
    if (!rst) begin
      state        <= IDLE;
      pc           <= '0;
      last         <= 1'b0;
      pending      <= 1'b0;
      cpu_gnt      <= 1'b0;
      overrun      <= 1'b0;
      mac_en       <= 1'b0;
      mac_zero     <= 1'b0;
      save_en      <= 1'b0;
      capture_en   <= 1'b0;
      capture_code <= '0;
      op_offset    <= '0;
      op_chan      <= '0;
      op_gain      <= '0;
    end else begin
      state   <= state_d;
      pc      <= pc_d;
      last    <= last_d;
      // a start seen while the CPU owns the RAM waits here until cpu_req drops
      pending <= (state == IDLE) & (start | pending) & cpu_req;
      cpu_gnt <= (state == IDLE) & cpu_req;
      if (ovr_clr)
        overrun <= 1'b0;
      else if (start && state != IDLE)
        overrun <= 1'b1;
      else if (OVR_CLEAR_ON_START && start)
        overrun <= 1'b0;
      mac_en     <= issue & ((opc == OP_MAC) | (opc == OP_MACZ));
      mac_zero   <= issue & (opc == OP_MACZ);
      save_en    <= issue & (opc == OP_SAVE);
      capture_en <= issue & is_cap;
      if (issue) begin
        op_offset <= prog_data[24:20];
        op_chan   <= prog_data[19:16];
        op_gain   <= prog_data[15:0];
      end
      if (issue && is_cap) capture_code <= opc[2:0];
    end
  end

endmodule

// File: tb/tb_dsp_sequencer.sv
// Directed bench for dsp_sequencer with an 8-word program RAM model (CODE_W=3).
module tb_dsp_sequencer;
  localparam int CW = 3;

  logic          ck = 1'b0;
  logic          rst, start, cpu_req, ovr_clr;
  logic [31:0]   prog_data;
  logic          cpu_gnt, prog_re, busy, done, overrun;
  logic          mac_en, mac_zero, save_en, capture_en;
  logic [CW-1:0] prog_addr;
  logic [2:0]    capture_code;
  logic [4:0]    op_offset;
  logic [3:0]    op_chan;
  logic [15:0]   op_gain;

  logic [31:0] mem [8];
  int nvec = 0, nerr = 0;
  int busy_cnt = 0, mac_cnt = 0, zero_rd = 0;
  int b0, m0, z0;

  dsp_sequencer #(.CODE_W(CW), .OVR_CLEAR_ON_START(1'b0)) dut (
    .ck(ck), .rst(rst), .start(start), .cpu_req(cpu_req), .cpu_gnt(cpu_gnt),
    .ovr_clr(ovr_clr), .prog_addr(prog_addr), .prog_re(prog_re), .prog_data(prog_data),
    .busy(busy), .done(done), .overrun(overrun), .mac_en(mac_en), .mac_zero(mac_zero),
    .save_en(save_en), .capture_en(capture_en), .capture_code(capture_code),
    .op_offset(op_offset), .op_chan(op_chan), .op_gain(op_gain)
  );

  always #5 ck = ~ck;

  always @(posedge ck) if (prog_re) prog_data <= mem[prog_addr];

  always @(posedge ck) begin
    if (busy) busy_cnt++;
    if (mac_en) mac_cnt++;
    if (busy && prog_re && prog_addr == '0) zero_rd++;
  end

  function automatic logic [31:0] w(input logic [6:0] op, input logic [4:0] off,
                                    input logic [3:0] ch, input logic [15:0] g);
    return {op, off, ch, g};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tk(input int n);
    repeat (n) @(posedge ck);
    #1;
  endtask

  task automatic load_prog1();
    for (int i = 0; i < 8; i++) mem[i] = '0;
    mem[0] = w(7'h42, 5'd4, 4'd1, 16'h2000);
    mem[1] = w(7'h40, 5'd5, 4'd1, 16'h89ab);
    mem[2] = w(7'h40, 5'd6, 4'd1, 16'h1234);
    mem[3] = w(7'h40, 5'd7, 4'd1, 16'h1111);
    mem[4] = w(7'h50, 5'd0, 4'd0, 16'h0000);
    mem[5] = w(7'h7f, 5'd0, 4'd0, 16'h0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start = 1'b0; cpu_req = 1'b0; ovr_clr = 1'b0;
    load_prog1();
    tk(2);
    chk("rst_flags", {busy, done, overrun, cpu_gnt, prog_re}, 0);
    chk("rst_strobes", {mac_en, mac_zero, save_en, capture_en, capture_code}, 0);
    chk("rst_ops", {prog_addr, op_offset, op_chan, op_gain}, 0);
    rst = 1'b1;
    tk(1);

    // MAC program: MACZ, 3xMAC, SAVE, HALT
    b0 = busy_cnt; m0 = mac_cnt;
    start = 1'b1; tk(1); start = 1'b0;
    chk("p1_fetch", {busy, prog_re, cpu_gnt}, 3'b110);
    chk("p1_fetch_addr", prog_addr, 0);
    tk(1);
    chk("p1_run_addr", prog_addr, 1);
    chk("p1_no_cmd_yet", mac_en, 0);
    tk(1);
    chk("p1_macz", {mac_en, mac_zero}, 2'b11);
    chk("p1_macz_ops", {op_offset, op_chan, op_gain}, {5'd4, 4'd1, 16'h2000});
    tk(1);
    chk("p1_mac1", {mac_en, mac_zero, op_offset, op_gain}, {2'b10, 5'd5, 16'h89ab});
    tk(1);
    chk("p1_mac2", {mac_en, mac_zero, op_offset, op_gain}, {2'b10, 5'd6, 16'h1234});
    tk(1);
    chk("p1_mac3", {mac_en, mac_zero, op_offset, op_gain}, {2'b10, 5'd7, 16'h1111});
    tk(1);
    chk("p1_save", {save_en, mac_en, prog_re, busy}, 4'b1001);
    tk(1);
    chk("p1_done", {done, busy, save_en}, 3'b100);
    tk(1);
    chk("p1_done_pulse", done, 0);
    chk("p1_busy_cycles", busy_cnt - b0, 7);
    chk("p1_mac_count", mac_cnt - m0, 4);

    // CAPTURE code 6, unknown opcode 0x55, HALT
    for (int i = 0; i < 8; i++) mem[i] = '0;
    mem[0] = w(7'h16, 5'd3, 4'd2, 16'h00aa);
    mem[1] = w(7'h55, 5'd1, 4'd1, 16'hbeef);
    mem[2] = w(7'h7f, 5'd0, 4'd0, 16'h0000);
    start = 1'b1; tk(1); start = 1'b0;
    tk(2);
    chk("p2_capture", {capture_en, capture_code, mac_en, save_en}, {1'b1, 3'd6, 2'b00});
    chk("p2_capture_gain", op_gain, 16'h00aa);
    tk(1);
    chk("p2_noop_strobes", {mac_en, mac_zero, save_en, capture_en}, 0);
    chk("p2_code_held", capture_code, 6);
    tk(1);
    chk("p2_done", done, 1);
    tk(1);

    // CPU ownership around a pending start
    cpu_req = 1'b1; tk(1);
    chk("gnt_idle", cpu_gnt, 1);
    start = 1'b1; tk(1); start = 1'b0;
    chk("gnt_hold", {busy, prog_re, cpu_gnt}, 3'b001);
    tk(2);
    chk("gnt_no_fetch", {busy, prog_re}, 0);
    cpu_req = 1'b0; tk(1);
    chk("gnt_release", {cpu_gnt, busy, prog_re}, 3'b011);
    chk("gnt_release_addr", prog_addr, 0);
    tk(1);
    cpu_req = 1'b1;
    tk(2);
    chk("gnt_run_ignored", {cpu_gnt, busy}, 2'b01);
    tk(1);
    chk("gnt_at_done", {done, cpu_gnt}, 2'b10);
    tk(2);
    chk("gnt_after_done", {cpu_gnt, busy}, 2'b10);
    cpu_req = 1'b0; tk(1);
    chk("gnt_no_rerun", {cpu_gnt, busy}, 0);

    // start while busy sets overrun; ovr_clr wins over a simultaneous start
    load_prog1();
    b0 = busy_cnt;
    start = 1'b1; tk(1); start = 1'b0;
    tk(2);
    start = 1'b1; tk(1); start = 1'b0;
    chk("ovr_set", {overrun, mac_en, op_gain}, {2'b11, 16'h89ab});
    tk(1);
    chk("ovr_sticky", {overrun, op_gain}, {1'b1, 16'h1234});
    start = 1'b1; ovr_clr = 1'b1; tk(1); start = 1'b0; ovr_clr = 1'b0;
    chk("ovr_clr_wins", {overrun, mac_en, op_gain}, {2'b01, 16'h1111});
    tk(2);
    chk("ovr_run_done", done, 1);
    tk(2);
    chk("ovr_no_restart", busy, 0);
    chk("ovr_busy_cycles", busy_cnt - b0, 7);

    // no HALT: all 8 words issue, no read of wrapped address 0
    for (int i = 0; i < 8; i++) mem[i] = w(7'h40, 5'(i), 4'd0, 16'(i));
    b0 = busy_cnt; m0 = mac_cnt; z0 = zero_rd;
    start = 1'b1; tk(1); start = 1'b0;
    tk(8);
    chk("end_word6", {mac_en, op_gain}, {1'b1, 16'd6});
    tk(1);
    chk("end_word7", {mac_en, op_gain}, {1'b1, 16'd7});
    chk("end_no_wrap", {busy, done, prog_re, prog_addr}, {3'b100, 3'd7});
    tk(1);
    chk("end_done", {done, mac_en, busy}, 3'b100);
    tk(1);
    chk("end_mac_count", mac_cnt - m0, 8);
    chk("end_zero_reads", zero_rd - z0, 1);
    chk("end_busy_cycles", busy_cnt - b0, 10);

    // reset during RUN, pending start discarded by reset, then rerun from 0
    load_prog1();
    start = 1'b1; tk(1); start = 1'b0;
    tk(2);
    chk("mid_pre", mac_en, 1);
    rst = 1'b0; tk(1);
    chk("mid_rst_strobes", {mac_en, mac_zero, save_en, capture_en}, 0);
    chk("mid_rst_flags", {busy, prog_re, op_gain}, 0);
    rst = 1'b1;
    cpu_req = 1'b1; start = 1'b1; tk(1); start = 1'b0;
    rst = 1'b0; tk(1);
    rst = 1'b1; cpu_req = 1'b0; tk(2);
    chk("mid_pending_gone", {busy, prog_re}, 0);
    start = 1'b1; tk(1); start = 1'b0;
    chk("rerun_fetch", {prog_re, prog_addr}, {1'b1, 3'd0});
    tk(2);
    chk("rerun_macz", {mac_en, mac_zero, op_gain}, {2'b11, 16'h2000});
    tk(6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
